// File: rtl/sbox_seq_pkg.sv
// Shared definitions for the S-box word sequencer.
// Contents: NIBBLE_W (nibble width) and the sequencer FSM state type.
package sbox_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nonlinear_lut.sv
// 4-bit to 4-bit combinational S-box.
// Ports: nibble (in, 4b), subst_c (out, 4b, combinational substitute).
module nonlinear_lut
    import sbox_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [NIBBLE_W-1:0] subst_c
);

    always_comb begin
        subst_c = '0;
        case (nibble)
            4'h0: subst_c = 4'h9;
            4'h1: subst_c = 4'h4;
            4'h2: subst_c = 4'h3;
            4'h3: subst_c = 4'hA;
            4'h4: subst_c = 4'hD;
            4'h5: subst_c = 4'h6;
            4'h6: subst_c = 4'hE;
            4'h7: subst_c = 4'h1;
            4'h8: subst_c = 4'h2;
            4'h9: subst_c = 4'hC;
            4'hA: subst_c = 4'h5;
            4'hB: subst_c = 4'hF;
            4'hC: subst_c = 4'h0;
            4'hD: subst_c = 4'h7;
            4'hE: subst_c = 4'h8;
            4'hF: subst_c = 4'hB;
            default: subst_c = '0;
        endcase
    end

endmodule

// File: rtl/sbox_word_sequencer.sv
// Serial S-box substitution of a W-bit word, one nibble per clock, using a
// single shared nonlinear_lut instance. Valid/ready on both sides.
// Ports:
//   clk, rst (async, active-high)
//   in_valid / in_ready / in_data [W-1:0]   - input word handshake
//   out_valid / out_ready / out_data [W-1:0] - result word handshake
//   busy                                     - FSM not in IDLE
//   key_in [W-1:0]                           - only with SBOX_KEY_MIX_EN
// Macro SBOX_KEY_MIX_EN: when defined, the accepted word is in_data ^ key_in.
module sbox_word_sequencer
    import sbox_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_data,
`ifdef SBOX_KEY_MIX_EN
    input  logic [NIBBLE_W*NIBBLES-1:0]   key_in,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_data,
    output logic                          busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_t               state;
    logic [W-1:0]         shreg;
    logic [CNT_W-1:0]     cnt;
    logic [W-1:0]         load_word;
    logic [NIBBLE_W-1:0]  sub_nib;

    // Word captured on acceptance
`ifdef SBOX_KEY_MIX_EN
    assign load_word = in_data ^ key_in;
`else
    assign load_word = in_data;
`endif

    nonlinear_lut u_lut (
        .nibble  (shreg[NIBBLE_W-1:0]),
        .subst_c (sub_nib)
    );

    // The result is read straight out of the shift register
    assign out_data = shreg;

    // Sequencer FSM: substituted nibble enters at the top, so after NIBBLES
    // shifts every nibble is back in its original position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        shreg    <= load_word;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    shreg <= {sub_nib, shreg[W-1:NIBBLE_W]};
                    if (cnt == LAST_NIB) begin
                        // Counter holds at the last index instead of wrapping
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_word_sequencer.sv
// Self-checking bench for sbox_word_sequencer (NIBBLES=4). Expected words come
// from a per-nibble table model; works with or without SBOX_KEY_MIX_EN.
module tb_sbox_word_sequencer;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;
    // S-box table, entry x at bits [4x+3:4x]
    localparam logic [63:0] SBOX_TABLE = 64'hB870_F5C2_1E6D_A349;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
`ifdef SBOX_KEY_MIX_EN
    logic [W-1:0] key_in;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sbox_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SBOX_KEY_MIX_EN
        .key_in    (key_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sbox_ref(input logic [3:0] x);
        logic [63:0] t;
        t = SBOX_TABLE;
        return t[4*x +: 4];
    endfunction

    // Expected result: S applied independently to each nibble of (data ^ key)
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] k);
        logic [W-1:0] v;
        logic [W-1:0] r;
        v = d;
`ifdef SBOX_KEY_MIX_EN
        v = d ^ k;
`endif
        r = '0;
        for (int i = 0; i < int'(NIB); i++) r[4*i +: 4] = sbox_ref(v[4*i +: 4]);
        return r;
    endfunction

    // Present a word, wait for acceptance and then for out_valid.
    // lat counts cycles from acceptance to the first out_valid.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] k, output bit ok, output int lat);
        int budget;
        ok  = 1'b0;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
`ifdef SBOX_KEY_MIX_EN
        key_in = k;
`else
        if (k != '0) lat = 0;
`endif
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
    endtask

    // Hold out_ready low for 'stall' cycles then complete the transfer.
    task automatic recv(input int stall, output logic [W-1:0] data, output bit stable);
        data   = out_data;
        stable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (out_data !== data || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef SBOX_KEY_MIX_EN
        key_in = '0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] dv [3];
        logic [W-1:0] ev [3];
        logic [W-1:0] got;
        bit ok, st;
        int lat;
        dv[0] = 16'h0000; ev[0] = 16'h9999;
        dv[1] = 16'h1234; ev[1] = 16'h43AD;
        dv[2] = 16'hC0DE; ev[2] = 16'h0978;
        for (int i = 0; i < 3; i++) begin
            send(dv[i], '0, ok, lat);
            checks++;
            if (!ok) begin failures++; $display("FAIL vec%0d_timeout got=0 exp=1", i); continue; end
            checks++;
            if (lat != int'(NIB) + 1) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, NIB + 1); end
            recv(0, got, st);
            checks++;
            if (got !== ev[i]) begin failures++; $display("FAIL vec%0d_data got=%h exp=%h", i, got, ev[i]); end
            checks++;
            if (got !== model(dv[i], '0)) begin failures++; $display("FAIL vec%0d_model got=%h exp=%h", i, got, model(dv[i], '0)); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d, k, got;
        bit ok, st;
        int lat, stall;
        for (int n = 0; n < 30; n++) begin
            d = W'($urandom);
            k = '0;
`ifdef SBOX_KEY_MIX_EN
            k = W'($urandom);
`endif
            stall = int'($urandom_range(0, 3));
            send(d, k, ok, lat);
            checks++;
            if (!ok || lat != int'(NIB) + 1) begin
                failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, NIB + 1);
                continue;
            end
            recv(stall, got, st);
            checks++;
            if (got !== model(d, k) || !st) begin
                failures++; $display("FAIL rand%0d_data got=%h stable=%0d exp=%h", n, got, st, model(d, k));
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] got, got2;
        bit ok, st;
        int lat;
        send(16'h1234, '0, ok, lat);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); return; end
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
`ifdef SBOX_KEY_MIX_EN
        key_in = '0;
`endif
        recv(10, got, st);
        checks++;
        if (!st) begin failures++; $display("FAIL stall_stable got=unstable exp=stable"); end
        checks++;
        if (got !== model(16'h1234, '0)) begin failures++; $display("FAIL stall_data got=%h exp=%h", got, model(16'h1234, '0)); end
        // One transfer only; the held 0xFFFF word is accepted right after
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_single_transfer got=%b exp=0", out_valid); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL stall_next_accept busy got=%b exp=1", busy); end
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        recv(0, got2, st);
        checks++;
        if (got2 !== 16'hBBBB) begin failures++; $display("FAIL stall_next_data got=%h exp=bbbb", got2); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        bit ok, st;
        int lat, budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1234;
`ifdef SBOX_KEY_MIX_EN
        key_in = '0;
`endif
        budget = 0;
        while (!in_ready && budget < 50) begin @(negedge clk); budget++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=v%b d%h b%b r%b exp=v0 d0000 b0 r0", out_valid, out_data, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_discard got=%b exp=0", out_valid); end
        send(16'hFFFF, '0, ok, lat);
        recv(0, got, st);
        checks++;
        if (!ok || got !== 16'hBBBB) begin failures++; $display("FAIL midreset_next got=%h exp=bbbb", got); end
    endtask

`ifdef SBOX_KEY_MIX_EN
    task automatic test_key_mix();
        logic [W-1:0] got;
        bit ok, st;
        int lat;
        send(16'h0000, 16'hFFFF, ok, lat);
        recv(0, got, st);
        checks++;
        if (!ok || got !== 16'hBBBB) begin failures++; $display("FAIL key_mix got=%h exp=bbbb", got); end
    endtask
`endif

    task automatic test_back_to_back();
        int acc_cyc [$];
        logic [W-1:0] exp_q [$];
        logic [W-1:0] e;
        out_ready = 1'b1;
`ifdef SBOX_KEY_MIX_EN
        key_in = '0;
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (out_data !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", out_data, e); end
            end
            in_valid = 1'b1;
            in_data  = W'($urandom);
            if (in_ready) begin
                acc_cyc.push_back(cyc);
                exp_q.push_back(model(in_data, '0));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (acc_cyc.size() < 3) begin failures++; $display("FAIL b2b_count got=%0d exp>=3", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != int'(NIB) + 2) begin
                failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], NIB + 2);
            end
        end
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out_data !== e) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", out_data, e); end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_stall();
        test_reset_mid();
`ifdef SBOX_KEY_MIX_EN
        test_key_mix();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sbox_word_sequencer.md
SBOX_WORD_SEQUENCER -- requirements
Module: sbox_word_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the word width in nibbles; W = 4*NIBBLES; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a word.
REQ-006 The block SHALL have port in_data, input, W bits, the plaintext word.
REQ-007 The block SHALL have port out_valid, output, 1 bit, meaning the result word is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-009 The block SHALL have port out_data, output, W bits, the substituted word.
REQ-010 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SUB and DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in SUB and DONE it SHALL be 0.
REQ-013 An in_valid&&in_ready cycle SHALL load in_data into a W-bit shift register, clear the nibble counter and move to SUB.
REQ-014 In SUB, each cycle SHALL apply the 4-bit S-box to shift-register bits [3:0], shift the register right by 4 and insert the substituted nibble at bits [W-1:W-4].
REQ-015 In SUB, the nibble counter SHALL increment each cycle; the cycle in which it equals NIBBLES-1 SHALL move to DONE.
REQ-016 After the transition in REQ-015, nibble i of the register SHALL hold S(nibble i of the loaded word) for every i, so nibble order is preserved.
REQ-017 The S-box SHALL be: 0->9, 1->4, 2->3, 3->A, 4->D, 5->6, 6->E, 7->1, 8->2, 9->C, A->5, B->F, C->0, D->7, E->8, F->B.
REQ-018 In DONE, out_valid SHALL be 1 and out_data SHALL equal the shift register.
REQ-019 In DONE, out_valid and out_data SHALL stay stable while out_ready is 0.
REQ-020 In DONE, out_ready=1 SHALL complete the transfer and return the FSM to IDLE.
REQ-021 Latency SHALL be NIBBLES+1 cycles from acceptance to the first out_valid; minimum spacing between acceptances SHALL be NIBBLES+2 cycles.
REQ-022 In_valid in SUB or DONE SHALL be ignored and no word SHALL be lost or overwritten.
REQ-023 The counter SHALL be ceil(log2(NIBBLES)) bits wide and SHALL never wrap within a word.

Reset
REQ-024 Asserting rst at any time, including mid-SUB or in DONE, SHALL force IDLE and zero the shift register and counter.
REQ-025 During reset, out_valid=0, out_data=0, busy=0 and in_ready=0; the in-flight word SHALL be discarded.
REQ-026 On the first clock edge after rst deasserts, in_ready SHALL be 1.

Configuration
REQ-027 With macro SBOX_KEY_MIX_EN defined, the block SHALL add input key_in [W-1:0], and the acceptance cycle SHALL load in_data XOR key_in.
REQ-028 Without SBOX_KEY_MIX_EN, the block SHALL have no key_in port and SHALL load in_data unmodified.

Structure
REQ-029 A shared package sbox_seq_pkg SHALL hold the FSM state typedef (IDLE/SUB/DONE) and the constant NIBBLE_W=4.
REQ-030 The S-box SHALL be one instance of the existing combinational sub-module nonlinear_lut (4-bit in, 4-bit out), reused every cycle.

Verification
REQ-031 Bench case: NIBBLES=4, in_data=0x0000 accepted, out_ready=1 -> out_data=0x9999 with out_valid 5 cycles after acceptance.
REQ-032 Bench case: in_data=0x1234 -> out_data 0x43AD; in_data=0xC0DE -> 0x0978.
REQ-033 Bench case: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and in_data=0xFFFF -> out_data stable, in_ready=0; then release -> one transfer, next word accepted.
REQ-034 Bench case: assert rst in the 2nd SUB cycle of 0x1234 -> outputs zero, busy=0; next word 0xFFFF -> 0xBBBB.
REQ-035 Bench case: with SBOX_KEY_MIX_EN defined, in_data=0x0000 and key_in=0xFFFF -> out_data=0xBBBB.
REQ-036 Bench case: back-to-back in_valid=1 for 20 cycles with out_ready=1 -> acceptances exactly 6 cycles apart.
